// File: rtl/imem_seq_ctrl.sv
// imem_seq_ctrl: loads a program into an external instruction memory, then
// sequences execution through it. The sequencer tracks the pc, applies
// stalls and branches, and halts at the program end or on a bad branch.
// Optional build macro: IMEM_SEQ_CHECKSUM_EN adds a running modular sum of
// the loaded words on load_csum. Without the macro, load_csum is tied to 0.
module imem_seq_ctrl #(
  parameter int PC_WIDTH  = 16,
  parameter int ISA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // program load
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [ISA_WIDTH-1:0] load_data,
  input  logic                 load_last,
  output logic                 load_ready,
  // execution control
  input  logic                 run_start,
  input  logic                 halt_req,
  input  logic                 stall,
  input  logic                 br_taken,
  input  logic [PC_WIDTH-1:0]  br_target,
  // memory side
  output logic                 mem_wen,
  output logic [PC_WIDTH-1:0]  mem_addr,
  output logic [ISA_WIDTH-1:0] mem_wdata,
  input  logic [ISA_WIDTH-1:0] mem_rdata,
  // status
  output logic [ISA_WIDTH-1:0] inst_out,
  output logic                 inst_valid,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH:0]    prog_len,
  output logic [1:0]           state,
  output logic                 br_err,
  output logic [ISA_WIDTH-1:0] load_csum
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  localparam logic [PC_WIDTH-1:0] PC_ONE  = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PC_WIDTH:0]   LEN_ONE = {{PC_WIDTH{1'b0}}, 1'b1};

  logic [1:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] laddr_q, laddr_d;
  logic [PC_WIDTH:0]   prog_len_q, prog_len_d;
  logic                br_err_q, br_err_d;

  // Next-state logic for the sequencer and the memory/status outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    laddr_d    = laddr_q;
    prog_len_d = prog_len_q;
    br_err_d   = br_err_q;
    load_ready = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = pc_q;
    mem_wdata  = '0;
    inst_out   = '0;
    inst_valid = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        // A load request takes precedence over a run request.
        if (load_start) begin
          state_d    = ST_LOAD;
          laddr_d    = '0;
          prog_len_d = '0;
          br_err_d   = 1'b0;
        end else if (run_start && (prog_len_q != '0)) begin
          state_d  = ST_RUN;
          pc_d     = '0;
          br_err_d = 1'b0;
        end
      end

      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          mem_wen    = 1'b1;
          mem_addr   = laddr_q;
          mem_wdata  = load_data;
          laddr_d    = laddr_q + PC_ONE;
          prog_len_d = prog_len_q + LEN_ONE;
          // Finish on the marked last word, or when the address space is full.
          if (load_last || (&laddr_q)) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_RUN: begin
        inst_out   = mem_rdata;
        inst_valid = !stall;
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (br_taken) begin
          if ({1'b0, br_target} < prog_len_q) begin
            pc_d = br_target;
          end else begin
            state_d  = ST_HALT;
            br_err_d = 1'b1;
          end
        end else if ({1'b0, pc_q} == (prog_len_q - LEN_ONE)) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_q + PC_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any load or run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= '0;
      laddr_q    <= '0;
      prog_len_q <= '0;
      br_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      laddr_q    <= laddr_d;
      prog_len_q <= prog_len_d;
      br_err_q   <= br_err_d;
    end
  end

`ifdef IMEM_SEQ_CHECKSUM_EN
  logic [ISA_WIDTH-1:0] csum_q, csum_d;

  // Running sum of accepted load words, restarted whenever a load begins.
  always_comb begin
    csum_d = csum_q;
    if (((state_q == ST_IDLE) || (state_q == ST_HALT)) && load_start) begin
      csum_d = '0;
    end else if ((state_q == ST_LOAD) && load_valid) begin
      csum_d = csum_q + load_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign load_csum = csum_q;
`else
  assign load_csum = '0;
`endif

  assign pc       = pc_q;
  assign prog_len = prog_len_q;
  assign state    = state_q;
  assign br_err   = br_err_q;

endmodule

// File: doc/imem_seq_ctrl.md
IMEM_SEQ_CTRL -- requirements
Module: imem_seq_ctrl

Interface
REQ-001 SHALL have parameters: PC_WIDTH, default 16, instruction address width; ISA_WIDTH, default 16, instruction word width.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports:
- load_start  in  1  begin program load.
- load_valid  in  1  load word present.
- load_data  in  ISA_WIDTH  load word.
- load_last  in  1  final word of load.
- load_ready  out  1  load word accepted this cycle when high together with load_valid.
REQ-004 SHALL have ports:
- run_start  in  1  begin execution at address 0.
- halt_req  in  1  stop execution.
- stall  in  1  hold pc.
- br_taken  in  1  redirect pc.
- br_target  in  PC_WIDTH  redirect address.
REQ-005 SHALL have memory-side ports: mem_wen out 1; mem_addr out PC_WIDTH; mem_wdata out ISA_WIDTH; mem_rdata in ISA_WIDTH (combinational read of mem_addr).
REQ-006 SHALL have status ports: inst_out out ISA_WIDTH; inst_valid out 1; pc out PC_WIDTH; prog_len out PC_WIDTH+1; state out 2; br_err out 1; load_csum out ISA_WIDTH.

Function
REQ-007 SHALL implement states IDLE=0, LOAD=1, RUN=2, HALT=3, presented on state.
REQ-008 IDLE/HALT: load_start -> LOAD, load address cleared to 0; else run_start with prog_len!=0 -> RUN, pc=0; run_start with prog_len==0 ignored; load_start wins over run_start.
REQ-009 LOAD: load_ready=1; each load_valid cycle drives mem_wen=1, mem_addr=load address, mem_wdata=load_data, then increments the load address.
REQ-010 LOAD exit: accepted word with load_last=1, or at address 2^PC_WIDTH-1 -> IDLE next cycle, prog_len=words accepted (max 2^PC_WIDTH).
REQ-011 Outside LOAD: mem_wen=0, load_ready=0, mem_wdata=0; load_valid ignored.
REQ-012 RUN: mem_addr=pc; inst_out=mem_rdata; inst_valid=!stall; pc updates once per cycle.
REQ-013 RUN pc priority: halt_req -> HALT, pc held; else stall -> pc held, br_taken ignored; else br_taken with br_target<prog_len -> pc=br_target; else br_taken with br_target>=prog_len -> HALT, br_err=1; else pc==prog_len-1 -> HALT; else pc+1.
REQ-014 Outside RUN: inst_valid=0, inst_out=0, mem_addr=pc; pc holds.
REQ-015 br_err SHALL remain 1 until the next run_start or load_start acceptance.
REQ-016 A new LOAD SHALL reset prog_len to 0 on entry; it SHALL never read memory.

Reset
REQ-017 rst_n=0 SHALL asynchronously force state=IDLE, pc=0, load address=0, prog_len=0, br_err=0, load_csum=0, all outputs 0; reset mid-LOAD or mid-RUN discards progress.
REQ-018 First state change SHALL occur on the first rising clk edge after rst_n deasserts.

Configuration
REQ-019 Macro IMEM_SEQ_CHECKSUM_EN defined: load_csum SHALL be cleared on LOAD entry and add each accepted load_data modulo 2^ISA_WIDTH; undefined: load_csum SHALL be constant 0, no adder.

Verification
REQ-020 Load 0x1111,0x2222,0x3333 (last on 3rd) -> mem_wen on addr 0,1,2, prog_len=3, IDLE, load_csum=0x6666 with macro.
REQ-021 run_start after REQ-020, no stall -> inst_out 0x1111,0x2222,0x3333 on consecutive cycles, then HALT with pc=2.
REQ-022 RUN with stall=1 and br_taken=1 at pc=1 for 2 cycles -> pc stays 1, inst_valid=0; release -> pc=2.
REQ-023 br_taken target=5, prog_len=3 -> HALT, br_err=1; target=0 -> pc=0, loop continues.
REQ-024 rst_n low mid-load after 2 words -> state IDLE, prog_len=0; run_start ignored.
REQ-025 load_start and run_start same cycle in HALT -> LOAD entered, br_err cleared.
